// File: rtl/proc_nios2_qsys_0_oci_trace_packer.sv
// Packs variable-length OCI trace fragments into fixed-size DCT words, with
// output backpressure, end-of-test flush of the partial word and a drop counter.
module proc_nios2_qsys_0_oci_trace_packer #(
    parameter int UNIT_W    = 2,
    parameter int BUF_UNITS = 15,
    parameter int IN_UNITS  = 4,
    parameter int CNT_W     = 4,
    parameter int DROP_W    = 16,
    localparam int LEN_W    = $clog2(IN_UNITS + 1)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IN_UNITS*UNIT_W-1:0]  in_data,
    input  logic [LEN_W-1:0]            in_len,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BUF_UNITS*UNIT_W-1:0] out_data,
    output logic [CNT_W-1:0]            out_count,
    input  logic                        test_ending,
    output logic                        test_has_ended,
    output logic [DROP_W-1:0]           drop_count
);

    typedef enum logic [1:0] {PACK, FLUSH, DONE} state_t;

    state_t                                   state;
    logic [BUF_UNITS*UNIT_W-1:0]              acc;
    logic [CNT_W-1:0]                         count;

    logic                                     out_free;
    logic                                     accept;
    logic [LEN_W-1:0]                         len;
    logic [CNT_W:0]                           total;
    logic [(BUF_UNITS+IN_UNITS)*UNIT_W-1:0]   merged;
    logic                                     load;
    logic [CNT_W-1:0]                         load_count;
    logic [BUF_UNITS*UNIT_W-1:0]              acc_next;
    logic [CNT_W-1:0]                         count_next;

    // merged holds acc[0..count-1] followed by the fragment, zero above total,
    // so acc never carries stale units and a flushed word is already zero-padded.
    always_comb begin
        out_free = !out_valid || out_ready;
        in_ready = (state == PACK) && out_free;
        accept   = in_valid && in_ready;
        len      = '0;
        if (accept) begin
            len = (in_len > LEN_W'(IN_UNITS)) ? LEN_W'(IN_UNITS) : in_len;
        end
        total = (CNT_W+1)'(count) + (CNT_W+1)'(len);

        merged = '0;
        for (int unsigned i = 0; i < BUF_UNITS; i++) begin
            if (i < 32'(count)) begin
                merged[i*UNIT_W +: UNIT_W] = acc[i*UNIT_W +: UNIT_W];
            end
        end
        for (int unsigned j = 0; j < IN_UNITS; j++) begin
            if (j < 32'(len)) begin
                merged[(32'(count) + j)*UNIT_W +: UNIT_W] = in_data[j*UNIT_W +: UNIT_W];
            end
        end

        load       = 1'b0;
        load_count = CNT_W'(BUF_UNITS);
        acc_next   = merged[BUF_UNITS*UNIT_W-1:0];
        count_next = total[CNT_W-1:0];
        case (state)
            PACK: begin
                if (total >= (CNT_W+1)'(BUF_UNITS)) begin
                    load       = 1'b1;
                    acc_next   = '0;
                    acc_next[IN_UNITS*UNIT_W-1:0] = merged[BUF_UNITS*UNIT_W +: IN_UNITS*UNIT_W];
                    count_next = CNT_W'(total - (CNT_W+1)'(BUF_UNITS));
                end
            end
            FLUSH: begin
                if (count != '0 && out_free) begin
                    load       = 1'b1;
                    load_count = count;
                    acc_next   = '0;
                    count_next = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= PACK;
            acc            <= '0;
            count          <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_count      <= '0;
            test_has_ended <= 1'b0;
            drop_count     <= '0;
        end else begin
            acc   <= acc_next;
            count <= count_next;
            case (state)
                PACK:    if (test_ending) state <= FLUSH;
                FLUSH:   if (count == '0 || out_free) state <= DONE;
                default: state <= DONE;
            endcase

            if (load) begin
                out_valid <= 1'b1;
                out_data  <= merged[BUF_UNITS*UNIT_W-1:0];
                out_count <= load_count;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            test_has_ended <= (state == DONE) && !out_valid;
            if (state == DONE && in_valid && drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule
